frame_write_arbiter: RTL and testbench

- Sole owner of the frame RAM write port.
- Arbitrates between three writers: the camera pixel stream, the paint cursor, and an internal clear engine that fills the frame with a background colour.
- Replaces the ad-hoc write mux in the top level; the VGA read port is unaffected.
- All RAM write-port signals are registered.

---
 rtl/frame_write_arbiter.sv | 144 ++++++++++++++
 tb/tb_frame_write_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_write_arbiter.sv
// ============================================================================
// frame_write_arbiter: sole owner of the frame RAM write port; arbitrates
// camera, paint cursor and a full-frame clear engine. Rev 1.0
// ============================================================================
`default_nettype none

module frame_write_arbiter #(
   parameter int                 ADDR_W      = 20,
   parameter int                 DATA_W      = 9,
   parameter int                 DEPTH       = 307200,
   parameter logic [DATA_W-1:0]  CLEAR_COLOR = DATA_W'(9'h1FF)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              mode,
   input  logic              clear_start,
   input  logic              status_clr,
   input  logic              cam_valid,
   input  logic [ADDR_W-1:0] cam_addr,
   input  logic [DATA_W-1:0] cam_data,
   input  logic              cur_valid,
   output logic              cur_ready,
   input  logic [ADDR_W-1:0] cur_addr,
   input  logic [DATA_W-1:0] cur_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              clear_busy,
   output logic              clear_done,
   output logic              cam_drop,
   output logic              addr_err
);

   localparam int                CNT_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t            state, next_state;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic              we_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] data_d;
   logic              done_d;
   logic              drop_set;
   logic              err_set;
   logic              cam_in_range;
   logic              cur_in_range;

   // Zero-extend so the compare is unsigned across the full address width.
   assign cam_in_range = ({1'b0, cam_addr} < DEPTH_EXT);
   assign cur_in_range = ({1'b0, cur_addr} < DEPTH_EXT);

   assign cur_ready  = reset_n && (state == IDLE) && !mode && !clear_start;
   assign clear_busy = (state == CLEAR);

   always_comb begin
      next_state = state;
      cnt_d      = cnt;
      we_d       = 1'b0;
      addr_d     = mem_addr;
      data_d     = mem_data;
      done_d     = 1'b0;
      drop_set   = 1'b0;
      err_set    = 1'b0;

      case (state)
         IDLE: begin
            if (clear_start) begin
               next_state = CLEAR;
               cnt_d      = '0;
               drop_set   = mode && cam_valid;
            end else if (mode) begin
               if (cam_valid) begin
                  if (cam_in_range) begin
                     we_d   = 1'b1;
                     addr_d = cam_addr;
                     data_d = cam_data;
                  end else begin
                     err_set = 1'b1;
                  end
               end
            end else if (cur_valid) begin
               if (cur_in_range) begin
                  we_d   = 1'b1;
                  addr_d = cur_addr;
                  data_d = cur_data;
               end else begin
                  err_set = 1'b1;
               end
            end
         end

         CLEAR: begin
            we_d     = 1'b1;
            addr_d   = ADDR_W'(cnt);
            data_d   = CLEAR_COLOR;
            drop_set = mode && cam_valid;
            if (cnt == LAST_CNT) begin
               next_state = IDLE;
               done_d     = 1'b1;
               cnt_d      = '0;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end

         default: begin
            next_state = IDLE;
            cnt_d      = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_data   <= '0;
         clear_done <= 1'b0;
         cam_drop   <= 1'b0;
         addr_err   <= 1'b0;
      end else begin
         state      <= next_state;
         cnt        <= cnt_d;
         mem_we     <= we_d;
         mem_addr   <= addr_d;
         mem_data   <= data_d;
         clear_done <= done_d;
         // Set wins over a simultaneous status clear.
         cam_drop   <= drop_set || (cam_drop && !status_clr);
         addr_err   <= err_set  || (addr_err && !status_clr);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_frame_write_arbiter.sv
// Randomized bench for frame_write_arbiter against a queue-based model of the
// write-port arbitration rules (small DEPTH so full clears are quick).
`default_nettype none

module tb_frame_write_arbiter;

   localparam int ADDR_W = 20;
   localparam int DATA_W = 9;
   localparam int DEPTH  = 16;
   localparam logic [DATA_W-1:0] CLR = 9'h1FF;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              mode = 1'b0;
   logic              clear_start = 1'b0;
   logic              status_clr = 1'b0;
   logic              cam_valid = 1'b0;
   logic [ADDR_W-1:0] cam_addr = '0;
   logic [DATA_W-1:0] cam_data = '0;
   logic              cur_valid = 1'b0;
   logic              cur_ready;
   logic [ADDR_W-1:0] cur_addr = '0;
   logic [DATA_W-1:0] cur_data = '0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              clear_busy;
   logic              clear_done;
   logic              cam_drop;
   logic              addr_err;

   frame_write_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CLEAR_COLOR(CLR)
   ) dut (
      .clk(clk), .reset_n(reset_n), .mode(mode), .clear_start(clear_start),
      .status_clr(status_clr), .cam_valid(cam_valid), .cam_addr(cam_addr),
      .cam_data(cam_data), .cur_valid(cur_valid), .cur_ready(cur_ready),
      .cur_addr(cur_addr), .cur_data(cur_data), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_data(mem_data), .clear_busy(clear_busy),
      .clear_done(clear_done), .cam_drop(cam_drop), .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: pending clear addresses are simply a queue.
   int                clr_q[$];
   bit                m_we, m_done, m_drop, m_err;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_data;
   bit                cur_acc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit exp_ready();
      return reset_n && (clr_q.size() == 0) && !mode && !clear_start;
   endfunction

   task automatic model_reset();
      clr_q.delete();
      m_we = 0; m_done = 0; m_drop = 0; m_err = 0;
      m_addr = '0; m_data = '0;
   endtask

   task automatic model_update();
      bit drop_ev, err_ev;
      int a;
      drop_ev = 0; err_ev = 0;
      if (!reset_n) begin
         model_reset();
         return;
      end
      m_we = 0; m_done = 0;
      if (clr_q.size() != 0) begin
         a = clr_q.pop_front();
         m_we = 1; m_addr = ADDR_W'(a); m_data = CLR;
         m_done = (a == DEPTH - 1);
         drop_ev = mode && cam_valid;
      end else if (clear_start) begin
         for (int i = 0; i < DEPTH; i++) clr_q.push_back(i);
         drop_ev = mode && cam_valid;
      end else if (mode) begin
         if (cam_valid) begin
            if (cam_addr < DEPTH) begin
               m_we = 1; m_addr = cam_addr; m_data = cam_data;
            end else err_ev = 1;
         end
      end else if (cur_valid) begin
         if (cur_addr < DEPTH) begin
            m_we = 1; m_addr = cur_addr; m_data = cur_data;
         end else err_ev = 1;
      end
      m_drop = drop_ev || (m_drop && !status_clr);
      m_err  = err_ev  || (m_err  && !status_clr);
   endtask

   task automatic check_outputs(input string pfx);
      check({pfx, "_we"},    32'(mem_we),     32'(m_we));
      check({pfx, "_addr"},  32'(mem_addr),   32'(m_addr));
      check({pfx, "_data"},  32'(mem_data),   32'(m_data));
      check({pfx, "_busy"},  32'(clear_busy), 32'(clr_q.size() != 0));
      check({pfx, "_done"},  32'(clear_done), 32'(m_done));
      check({pfx, "_drop"},  32'(cam_drop),   32'(m_drop));
      check({pfx, "_err"},   32'(addr_err),   32'(m_err));
   endtask

   // Inputs are applied at the negedge before calling; returns at next negedge.
   task automatic cycle();
      #1;
      check("cur_ready", 32'(cur_ready), 32'(exp_ready()));
      cur_acc = cur_valid && exp_ready();
      @(posedge clk);
      model_update();
      #1;
      check_outputs("out");
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      clear_start = 0; status_clr = 0; cam_valid = 0; cur_valid = 0;
   endtask

   initial begin
      int guard;
      model_reset();
      #1;
      check_outputs("reset");
      check("reset_ready", 32'(cur_ready), 32'(0));
      @(negedge clk);
      @(negedge clk);
      reset_n = 1;

      // Camera write in camera mode.
      mode = 1; cam_valid = 1; cam_addr = 20'd10; cam_data = 9'h0AA;
      cycle();
      check("cam_wr_addr", 32'(mem_addr), 32'd10);
      idle_inputs(); cycle();

      // Cursor write in paint mode with a camera pixel present.
      mode = 0; cur_valid = 1; cur_addr = 20'd5; cur_data = 9'h1C0; cam_valid = 1;
      cycle();
      check("cur_wr_data", 32'(mem_data), 32'h1C0);
      idle_inputs(); cycle();

      // Full clear with camera traffic, a second clear_start and a held cursor.
      mode = 1; clear_start = 1; cam_valid = 1; cam_addr = 20'd3;
      cycle();
      clear_start = 0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         clear_start = (i == 5);
         if (i == DEPTH - 2) mode = 0;
         cur_valid = 1; cur_addr = 20'd9; cur_data = 9'h015;
         cycle();
      end
      check("drop_after_clear", 32'(cam_drop), 32'd1);
      idle_inputs(); status_clr = 1; cycle();
      idle_inputs(); cycle();

      // Out-of-range cursor addresses and set-wins-over-clear.
      mode = 0; cur_valid = 1; cur_addr = 20'd16; cur_data = 9'h077;
      cycle();
      cur_addr = 20'hFFFFF; status_clr = 1;
      cycle();
      check("err_sticky", 32'(addr_err), 32'd1);
      idle_inputs(); cycle();

      // Reset in the middle of a clear.
      clear_start = 1; cycle(); clear_start = 0;
      guard = 0;
      while (!(m_we && m_addr == 7 && clr_q.size() != 0) && guard < 40) begin
         cycle(); guard++;
      end
      check("wait_addr7_timeout", 32'(guard < 40), 32'd1);
      #2 reset_n = 0;
      model_reset();
      #1;
      check_outputs("midrst");
      check("midrst_ready", 32'(cur_ready), 32'd0);
      @(negedge clk);
      cycle(); cycle();
      reset_n = 1;
      clear_start = 1; cycle(); clear_start = 0;
      cycle();
      check("restart_addr0", 32'(mem_addr), 32'd0);

      // Randomized traffic.
      cur_acc = 1;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 29) == 0) mode = ~mode;
         clear_start = ($urandom_range(0, 49) == 0);
         status_clr  = ($urandom_range(0, 7) == 0);
         cam_valid   = $urandom_range(0, 1);
         cam_addr    = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 19));
         cam_data    = DATA_W'($urandom);
         if (!cur_valid || cur_acc) begin
            cur_valid = $urandom_range(0, 1);
            cur_addr  = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 19));
            cur_data  = DATA_W'($urandom);
         end
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
